// File: rtl/fdiv_writeback.sv
// rtl/fdiv_writeback.sv - fdiv result FIFO, register-file writeback and pending-write scoreboard
module fdiv_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    input  logic          res_flag,
    input  logic [AW-1:0] res_addr,
    input  logic [31:0]   res_data,
    output logic          stall_issue,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [31:0]   wb_data,
    input  logic          wb_ready,
    input  logic [AW-1:0] pend_query_addr,
    output logic          pend_hit,
    output logic          err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 1 << AW;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] pend_cnt [NREG];

    logic            empty;
    logic            full;
    logic            res_acc;
    logic            retire;
    logic            enq;
    logic            drop;
    logic [NREG-1:0] pend_inc;
    logic [NREG-1:0] pend_dec;

    // A result arriving with nothing in flight is left over from before a reset.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        res_acc = res_flag && (inflight != '0);
        retire  = !empty && wb_ready;
        enq     = res_acc && (!full || retire);
        drop    = res_acc && full && !retire;
    end

    assign wb_valid    = !empty;
    assign wb_addr     = empty ? '0 : mem_addr[rd_ptr];
    assign wb_data     = empty ? '0 : mem_data[rd_ptr];
    assign stall_issue = ({1'b0, inflight} + {1'b0, count}) >= (CW + 1)'(DEPTH);
    assign pend_hit    = (pend_cnt[pend_query_addr] != '0);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[wr_ptr] <= res_addr;
            mem_data[wr_ptr] <= res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({issue_valid, res_acc})
                2'b10:   if (inflight != CW'(DEPTH)) inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (drop) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        if (issue_valid) begin
            pend_inc[issue_addr] = 1'b1;
        end
        if (retire) begin
            pend_dec[wb_addr] = 1'b1;
        end
    end

    // Counters saturate at both ends; a simultaneous issue and retire cancel.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                pend_cnt[i] <= '0;
            end else if (pend_inc[i] && !pend_dec[i] && (pend_cnt[i] != '1)) begin
                pend_cnt[i] <= pend_cnt[i] + CW'(1);
            end else if (pend_dec[i] && !pend_inc[i] && (pend_cnt[i] != '0)) begin
                pend_cnt[i] <= pend_cnt[i] - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fdiv_writeback.sv
// tb/tb_fdiv_writeback.sv - scoreboard bench for fdiv_writeback with directed and random traffic
module tb_fdiv_writeback;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        res_flag = 1'b0;
    logic [4:0]  res_addr = '0;
    logic [31:0] res_data = '0;
    logic        stall_issue;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready = 1'b0;
    logic [4:0]  pend_query_addr = '0;
    logic        pend_hit;
    logic        err;

    fdiv_writeback #(.DEPTH(DEPTH), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .res_flag(res_flag), .res_addr(res_addr), .res_data(res_data),
        .stall_issue(stall_issue),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .pend_query_addr(pend_query_addr), .pend_hit(pend_hit), .err(err)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    ent_t mfifo[$];
    ent_t exp_q[$];
    ent_t pipe[$];
    int   m_inflight = 0;
    int   pend[32];
    bit   m_err = 1'b0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state after each clock edge, from the inputs held across that edge.
    always @(posedge clk) begin
        ent_t h;
        bit   deq;
        bit   acc;
        if (rst) begin
            mfifo.delete();
            exp_q.delete();
            m_inflight = 0;
            foreach (pend[i]) pend[i] = 0;
            m_err  = 1'b0;
            mon_en = 1'b1;
        end else begin
            deq = (mfifo.size() > 0) && wb_ready;
            acc = res_flag && (m_inflight > 0);
            h.a = '0;
            h.d = '0;
            if (deq) h = mfifo.pop_front();
            if (acc) begin
                if (mfifo.size() < DEPTH) begin
                    mfifo.push_back('{res_addr, res_data});
                    exp_q.push_back('{res_addr, res_data});
                end else begin
                    m_err = 1'b1;
                end
            end
            m_inflight = m_inflight + (issue_valid ? 1 : 0) - (acc ? 1 : 0);
            if (!(issue_valid && deq && issue_addr == h.a)) begin
                if (issue_valid) pend[issue_addr]++;
                if (deq && pend[h.a] > 0) pend[h.a]--;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on each retire.
    always @(negedge clk) begin
        ent_t e;
        if (mon_en) begin
            chk("wb_valid", 32'(wb_valid), 32'(mfifo.size() != 0));
            chk("wb_addr", 32'(wb_addr), mfifo.size() != 0 ? 32'(mfifo[0].a) : 32'd0);
            chk("wb_data", wb_data, mfifo.size() != 0 ? mfifo[0].d : 32'd0);
            chk("stall_issue", 32'(stall_issue), 32'((m_inflight + mfifo.size()) >= DEPTH));
            chk("err", 32'(err), 32'(m_err));
            chk("pend_hit", 32'(pend_hit), 32'(pend[pend_query_addr] != 0));
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL retire_unexpected: got addr %0d data %0h expected none", wb_addr, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_addr", 32'(wb_addr), 32'(e.a));
                    chk("retire_data", wb_data, e.d);
                end
            end
        end
    end

    task automatic drive(input bit iv, input logic [4:0] ia, input bit rf, input logic [4:0] ra,
                         input logic [31:0] rd, input bit rdy, input logic [4:0] q);
        @(posedge clk);
        #1;
        issue_valid     = iv;
        issue_addr      = ia;
        res_flag        = rf;
        res_addr        = ra;
        res_data        = rd;
        wb_ready        = rdy;
        pend_query_addr = q;
    endtask

    task automatic idle(input int n, input bit rdy, input logic [4:0] q);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, rdy, q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset
        idle(2, 1'b0, 5'd0);
        rst = 1'b0;
        idle(1, 1'b0, 5'd0);
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_stall", 32'(stall_issue), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // Single op
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
        idle(3, 1'b1, 5'd5);
        drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h3F800000, 1'b1, 5'd5);
        idle(1, 1'b1, 5'd5);
        chk("single_wb_valid", 32'(wb_valid), 32'd1);
        chk("single_wb_data", wb_data, 32'h3F800000);
        chk("single_pend_before", 32'(pend_hit), 32'd1);
        idle(1, 1'b1, 5'd5);
        chk("single_wb_done", 32'(wb_valid), 32'd0);
        chk("single_pend_after", 32'(pend_hit), 32'd0);

        // Backpressure
        for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd1);
        idle(1, 1'b0, 5'd1);
        chk("bp_stall_after_issue", 32'(stall_issue), 32'd1);
        drive(1'b0, 5'd0, 1'b1, 5'd1, 32'h3F800000, 1'b0, 5'd1);
        drive(1'b0, 5'd0, 1'b1, 5'd2, 32'h40000000, 1'b0, 5'd1);
        drive(1'b0, 5'd0, 1'b1, 5'd3, 32'h40400000, 1'b0, 5'd1);
        drive(1'b0, 5'd0, 1'b1, 5'd4, 32'h40800000, 1'b0, 5'd1);
        idle(2, 1'b0, 5'd1);
        chk("bp_full_stall", 32'(stall_issue), 32'd1);
        chk("bp_head_addr", 32'(wb_addr), 32'd1);
        idle(1, 1'b1, 5'd2);
        idle(1, 1'b1, 5'd2);
        chk("bp_stall_fall", 32'(stall_issue), 32'd0);
        chk("bp_second_head", 32'(wb_addr), 32'd2);
        idle(4, 1'b1, 5'd4);

        // Full plus simultaneous enqueue and dequeue
        for (int i = 8; i < 12; i++) drive(1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd12);
        for (int i = 8; i < 12; i++) drive(1'b0, 5'd0, 1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b0, 5'd12);
        drive(1'b1, 5'd12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd12);
        drive(1'b0, 5'd0, 1'b1, 5'd12, 32'hA000_000C, 1'b1, 5'd12);
        idle(1, 1'b0, 5'd12);
        chk("full_simul_err", 32'(err), 32'd0);
        chk("full_simul_head", 32'(wb_addr), 32'd9);

        // Violation: issue under stall while full, no dequeue
        drive(1'b1, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 5'd13);
        drive(1'b0, 5'd0, 1'b1, 5'd13, 32'hDEADBEEF, 1'b0, 5'd13);
        idle(1, 1'b0, 5'd13);
        chk("violation_err", 32'(err), 32'd1);
        idle(6, 1'b1, 5'd12);
        chk("violation_err_sticky", 32'(err), 32'd1);

        // Mid-op reset
        rst = 1'b1;
        idle(1, 1'b0, 5'd0);
        rst = 1'b0;
        drive(1'b1, 5'd20, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
        drive(1'b1, 5'd21, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
        rst = 1'b1;
        idle(1, 1'b1, 5'd20);
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b1, 5'd20, 32'h11111111, 1'b1, 5'd20);
        drive(1'b0, 5'd0, 1'b1, 5'd21, 32'h22222222, 1'b1, 5'd21);
        idle(2, 1'b1, 5'd20);
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_pend", 32'(pend_hit), 32'd0);

        // Same register twice
        drive(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        drive(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        idle(2, 1'b1, 5'd7);
        drive(1'b0, 5'd0, 1'b1, 5'd7, 32'h40E00000, 1'b1, 5'd7);
        idle(2, 1'b1, 5'd7);
        chk("same_reg_after_first", 32'(pend_hit), 32'd1);
        drive(1'b0, 5'd0, 1'b1, 5'd7, 32'h41000000, 1'b1, 5'd7);
        idle(2, 1'b1, 5'd7);
        chk("same_reg_after_second", 32'(pend_hit), 32'd0);

        // Random traffic obeying stall_issue
        rst = 1'b1;
        idle(1, 1'b0, 5'd0);
        rst = 1'b0;
        pipe.delete();
        for (int c = 0; c < 500; c++) begin
            bit          iv;
            bit          rf;
            logic [4:0]  ia;
            logic [4:0]  ra;
            logic [31:0] rd;
            ent_t        e;
            rf = 1'b0;
            ra = '0;
            rd = '0;
            if (pipe.size() > 0 && $urandom_range(2) != 0) begin
                e  = pipe.pop_front();
                rf = 1'b1;
                ra = e.a;
                rd = e.d;
            end
            iv = !stall_issue && ($urandom_range(1) == 1);
            ia = 5'($urandom_range(7));
            if (iv) pipe.push_back('{ia, $urandom()});
            drive(iv, ia, rf, ra, rd, $urandom_range(3) != 0,
                  $urandom_range(1) == 1 ? ia : 5'($urandom_range(31)));
        end
        while (pipe.size() > 0) begin
            ent_t e;
            e = pipe.pop_front();
            drive(1'b0, 5'd0, 1'b1, e.a, e.d, 1'b1, e.a);
        end
        idle(8, 1'b1, 5'd0);
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
